// File: rtl/ldst_issue_queue.sv
// In-order load/store issue queue feeding the memory access unit.
// Ports: dispatch_* in (valid/ready), wb_* wakeup bus, issue_* out, count_o.
module ldst_issue_queue #(
   parameter int ENTRY_NUM = 4,
   parameter int DATA_LEN  = 32,
   parameter int TAG_LEN   = 6
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         kill_i,
   input  logic                         dispatch_valid_i,
   output logic                         dispatch_ready_o,
   input  logic [DATA_LEN-1:0]          dispatch_src1_i,
   input  logic                         dispatch_src1_rdy_i,
   input  logic [DATA_LEN-1:0]          dispatch_src2_i,
   input  logic                         dispatch_src2_rdy_i,
   input  logic [DATA_LEN-1:0]          dispatch_imm_i,
   input  logic                         dispatch_if_write_rrf_i,
   input  logic [TAG_LEN-1:0]           dispatch_rrf_tag_i,
   input  logic                         wb_valid_i,
   input  logic [TAG_LEN-1:0]           wb_tag_i,
   input  logic [DATA_LEN-1:0]          wb_data_i,
   input  logic                         issue_stall_i,
   output logic                         issue_o,
   output logic [DATA_LEN-1:0]          src1_o,
   output logic [DATA_LEN-1:0]          src2_o,
   output logic [DATA_LEN-1:0]          imm_o,
   output logic                         if_write_rrf_o,
   output logic [TAG_LEN-1:0]           rrf_tag_o,
   output logic [$clog2(ENTRY_NUM):0]   count_o
);

   localparam int PTR_W = $clog2(ENTRY_NUM);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_NUM-1:0] r_valid;
   logic [ENTRY_NUM-1:0] r_rdy1;
   logic [ENTRY_NUM-1:0] r_rdy2;
   logic [ENTRY_NUM-1:0] r_wr;
   logic [DATA_LEN-1:0]  r_src1 [ENTRY_NUM];
   logic [DATA_LEN-1:0]  r_src2 [ENTRY_NUM];
   logic [DATA_LEN-1:0]  r_imm  [ENTRY_NUM];
   logic [TAG_LEN-1:0]   r_tag  [ENTRY_NUM];
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;

   logic w_disp;
   logic w_cap1;
   logic w_cap2;
   logic w_head_rdy;

   // No bypass when full: readiness depends only on stored occupancy.
   assign dispatch_ready_o = (r_count != CNT_W'(ENTRY_NUM)) & ~kill_i;
   assign w_disp = dispatch_valid_i & dispatch_ready_o;

   // A source whose producer broadcasts in the dispatch cycle is captured now.
   assign w_cap1 = ~dispatch_src1_rdy_i & wb_valid_i &
                   (dispatch_src1_i[TAG_LEN-1:0] == wb_tag_i);
   assign w_cap2 = ~dispatch_src2_rdy_i & wb_valid_i &
                   (dispatch_src2_i[TAG_LEN-1:0] == wb_tag_i);

   assign w_head_rdy = r_valid[r_head] & r_rdy1[r_head] & r_rdy2[r_head];
   assign issue_o    = w_head_rdy & ~issue_stall_i & ~kill_i;

   assign src1_o         = r_src1[r_head];
   assign src2_o         = r_src2[r_head];
   assign imm_o          = r_imm[r_head];
   assign if_write_rrf_o = r_wr[r_head];
   assign rrf_tag_o      = r_tag[r_head];
   assign count_o        = r_count;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_valid <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
         r_wr    <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            r_src1[i] <= '0;
            r_src2[i] <= '0;
            r_imm[i]  <= '0;
            r_tag[i]  <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (kill_i) begin
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // Wakeup of waiting sources from the writeback bus.
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (wb_valid_i && r_valid[i]) begin
               if (!r_rdy1[i] && r_src1[i][TAG_LEN-1:0] == wb_tag_i) begin
                  r_src1[i] <= wb_data_i;
                  r_rdy1[i] <= 1'b1;
               end
               if (!r_rdy2[i] && r_src2[i][TAG_LEN-1:0] == wb_tag_i) begin
                  r_src2[i] <= wb_data_i;
                  r_rdy2[i] <= 1'b1;
               end
            end
         end
         if (issue_o) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end
         // The tail slot is always free here, so it never collides with wakeup.
         if (w_disp) begin
            r_valid[r_tail] <= 1'b1;
            r_src1[r_tail]  <= w_cap1 ? wb_data_i : dispatch_src1_i;
            r_rdy1[r_tail]  <= dispatch_src1_rdy_i | w_cap1;
            r_src2[r_tail]  <= w_cap2 ? wb_data_i : dispatch_src2_i;
            r_rdy2[r_tail]  <= dispatch_src2_rdy_i | w_cap2;
            r_imm[r_tail]   <= dispatch_imm_i;
            r_wr[r_tail]    <= dispatch_if_write_rrf_i;
            r_tag[r_tail]   <= dispatch_rrf_tag_i;
            r_tail          <= r_tail + PTR_W'(1);
         end
         unique case ({w_disp, issue_o})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ldst_issue_queue.sv
// Bench for ldst_issue_queue: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_ldst_issue_queue;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        kill_i;
   logic        dispatch_valid_i;
   logic        dispatch_ready_o;
   logic [31:0] dispatch_src1_i;
   logic        dispatch_src1_rdy_i;
   logic [31:0] dispatch_src2_i;
   logic        dispatch_src2_rdy_i;
   logic [31:0] dispatch_imm_i;
   logic        dispatch_if_write_rrf_i;
   logic [5:0]  dispatch_rrf_tag_i;
   logic        wb_valid_i;
   logic [5:0]  wb_tag_i;
   logic [31:0] wb_data_i;
   logic        issue_stall_i;
   logic        issue_o;
   logic [31:0] src1_o;
   logic [31:0] src2_o;
   logic [31:0] imm_o;
   logic        if_write_rrf_o;
   logic [5:0]  rrf_tag_o;
   logic [2:0]  count_o;

   ldst_issue_queue #(
      .ENTRY_NUM (4),
      .DATA_LEN  (32),
      .TAG_LEN   (6)
   ) dut (
      .clk_i                   (clk_i),
      .reset_i                 (reset_i),
      .kill_i                  (kill_i),
      .dispatch_valid_i        (dispatch_valid_i),
      .dispatch_ready_o        (dispatch_ready_o),
      .dispatch_src1_i         (dispatch_src1_i),
      .dispatch_src1_rdy_i     (dispatch_src1_rdy_i),
      .dispatch_src2_i         (dispatch_src2_i),
      .dispatch_src2_rdy_i     (dispatch_src2_rdy_i),
      .dispatch_imm_i          (dispatch_imm_i),
      .dispatch_if_write_rrf_i (dispatch_if_write_rrf_i),
      .dispatch_rrf_tag_i      (dispatch_rrf_tag_i),
      .wb_valid_i              (wb_valid_i),
      .wb_tag_i                (wb_tag_i),
      .wb_data_i               (wb_data_i),
      .issue_stall_i           (issue_stall_i),
      .issue_o                 (issue_o),
      .src1_o                  (src1_o),
      .src2_o                  (src2_o),
      .imm_o                   (imm_o),
      .if_write_rrf_o          (if_write_rrf_o),
      .rrf_tag_o               (rrf_tag_o),
      .count_o                 (count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] s1;
      bit          r1;
      logic [31:0] s2;
      bit          r2;
      logic [31:0] imm;
      bit          wr;
      logic [5:0]  tag;
   } op_t;

   op_t q[$];
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
      end
   endtask

   task automatic idle();
      kill_i = 0;
      dispatch_valid_i = 0;
      dispatch_src1_i = 0;
      dispatch_src1_rdy_i = 1;
      dispatch_src2_i = 0;
      dispatch_src2_rdy_i = 1;
      dispatch_imm_i = 0;
      dispatch_if_write_rrf_i = 0;
      dispatch_rrf_tag_i = 0;
      wb_valid_i = 0;
      wb_tag_i = 0;
      wb_data_i = 0;
      issue_stall_i = 0;
   endtask

   task automatic disp(logic [31:0] s1, bit r1, logic [31:0] s2, bit r2,
                       logic [31:0] imm, bit wr, logic [5:0] tag);
      dispatch_valid_i = 1;
      dispatch_src1_i = s1;
      dispatch_src1_rdy_i = r1;
      dispatch_src2_i = s2;
      dispatch_src2_rdy_i = r2;
      dispatch_imm_i = imm;
      dispatch_if_write_rrf_i = wr;
      dispatch_rrf_tag_i = tag;
   endtask

   // Called at a negedge with inputs driven; compares, advances model
   // across the next posedge, returns at the following negedge.
   task automatic step();
      bit  e_rdy;
      bit  e_iss;
      bit  f_d;
      op_t n;
      #1;
      e_rdy = (q.size() != 4) && !kill_i;
      e_iss = (q.size() > 0) && q[0].r1 && q[0].r2 && !issue_stall_i && !kill_i;
      check("ready", 32'(dispatch_ready_o), 32'(e_rdy));
      check("count", 32'(count_o), 32'(q.size()));
      check("issue", 32'(issue_o), 32'(e_iss));
      if (e_iss) begin
         check("src1", src1_o, q[0].s1);
         check("src2", src2_o, q[0].s2);
         check("imm", imm_o, q[0].imm);
         check("wr", 32'(if_write_rrf_o), 32'(q[0].wr));
         check("tag", 32'(rrf_tag_o), 32'(q[0].tag));
      end
      f_d = dispatch_valid_i && e_rdy;
      @(posedge clk_i);
      if (kill_i) begin
         q.delete();
      end else begin
         if (wb_valid_i) begin
            foreach (q[i]) begin
               if (!q[i].r1 && q[i].s1[5:0] == wb_tag_i) begin
                  q[i].s1 = wb_data_i;
                  q[i].r1 = 1;
               end
               if (!q[i].r2 && q[i].s2[5:0] == wb_tag_i) begin
                  q[i].s2 = wb_data_i;
                  q[i].r2 = 1;
               end
            end
         end
         if (e_iss) void'(q.pop_front());
         if (f_d) begin
            n.s1 = dispatch_src1_i;
            n.r1 = dispatch_src1_rdy_i;
            n.s2 = dispatch_src2_i;
            n.r2 = dispatch_src2_rdy_i;
            if (!n.r1 && wb_valid_i && n.s1[5:0] == wb_tag_i) begin
               n.s1 = wb_data_i;
               n.r1 = 1;
            end
            if (!n.r2 && wb_valid_i && n.s2[5:0] == wb_tag_i) begin
               n.s2 = wb_data_i;
               n.r2 = 1;
            end
            n.imm = dispatch_imm_i;
            n.wr = dispatch_if_write_rrf_i;
            n.tag = dispatch_rrf_tag_i;
            q.push_back(n);
         end
      end
      @(negedge clk_i);
   endtask

   initial begin
      idle();
      #2;
      check("rst_issue", 32'(issue_o), 32'(0));
      check("rst_count", 32'(count_o), 32'(0));
      check("rst_ready", 32'(dispatch_ready_o), 32'(1));
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 0;

      // Ready load, issues the next cycle.
      disp(32'h100, 1, 32'h0, 1, 32'h8, 1, 6'd5);
      step();
      idle();
      #1;
      check("t1_issue", 32'(issue_o), 32'(1));
      check("t1_src1", src1_o, 32'h100);
      check("t1_imm", imm_o, 32'h8);
      check("t1_wr", 32'(if_write_rrf_o), 32'(1));
      check("t1_tag", 32'(rrf_tag_o), 32'(5));
      step();
      step();

      // Store with src2 waiting on tag 9.
      disp(32'h200, 1, 32'h9, 0, 32'h4, 0, 6'd0);
      step();
      idle();
      step();
      step();
      wb_valid_i = 1;
      wb_tag_i = 6'd9;
      wb_data_i = 32'hDEAD;
      step();
      idle();
      #1;
      check("t2_issue", 32'(issue_o), 32'(1));
      check("t2_src2", src2_o, 32'hDEAD);
      step();
      step();

      // Ordering: A waits on tag 3, ready B stays behind it.
      disp(32'h3, 0, 32'h1, 1, 32'h0, 1, 6'd10);
      step();
      disp(32'h5, 1, 32'h6, 1, 32'h0, 1, 6'd11);
      step();
      idle();
      repeat (3) step();
      wb_valid_i = 1;
      wb_tag_i = 6'd3;
      wb_data_i = 32'h333;
      step();
      idle();
      #1;
      check("t3_a", 32'(rrf_tag_o), 32'(10));
      step();
      check("t3_b", 32'(rrf_tag_o), 32'(11));
      step();
      step();

      // Full and wrap, three rounds.
      for (int r = 0; r < 3; r++) begin
         issue_stall_i = 1;
         for (int k = 0; k < 5; k++) begin
            disp(32'(r * 16 + k), 1, 32'h0, 1, 32'h0, 1, 6'(k));
            step();
         end
         idle();
         issue_stall_i = 1;
         #1;
         check("full_ready", 32'(dispatch_ready_o), 32'(0));
         issue_stall_i = 0;
         repeat (5) step();
      end

      // Same-cycle capture of src1.
      disp(32'h7, 0, 32'h0, 1, 32'h0, 0, 6'd0);
      wb_valid_i = 1;
      wb_tag_i = 6'd7;
      wb_data_i = 32'h42;
      step();
      idle();
      #1;
      check("t5_src1", src1_o, 32'h42);
      step();
      step();

      // Kill with three queued.
      issue_stall_i = 1;
      for (int k = 0; k < 3; k++) begin
         disp(32'h0, 1, 32'h0, 1, 32'h0, 1, 6'(k));
         step();
      end
      idle();
      kill_i = 1;
      step();
      idle();
      #1;
      check("kill_count", 32'(count_o), 32'(0));
      check("kill_issue", 32'(issue_o), 32'(0));
      step();

      // Refill two, then async reset mid-cycle.
      issue_stall_i = 1;
      for (int k = 0; k < 2; k++) begin
         disp(32'h0, 1, 32'h0, 1, 32'h0, 1, 6'(k));
         step();
      end
      idle();
      issue_stall_i = 0;
      #1;
      check("pre_rst_issue", 32'(issue_o), 32'(1));
      #1;
      reset_i = 1;
      #1;
      check("arst_issue", 32'(issue_o), 32'(0));
      check("arst_count", 32'(count_o), 32'(0));
      check("arst_ready", 32'(dispatch_ready_o), 32'(1));
      q.delete();
      @(negedge clk_i);
      reset_i = 0;

      // Random traffic.
      for (int c = 0; c < 2000; c++) begin
         kill_i = ($urandom_range(0, 49) == 0);
         issue_stall_i = ($urandom_range(0, 3) == 0);
         dispatch_valid_i = $urandom_range(0, 1);
         dispatch_src1_rdy_i = $urandom_range(0, 1);
         dispatch_src2_rdy_i = $urandom_range(0, 1);
         dispatch_src1_i = {$urandom_range(0, 65535), 13'd0,
                            3'($urandom_range(0, 7))};
         dispatch_src2_i = {$urandom_range(0, 65535), 13'd0,
                            3'($urandom_range(0, 7))};
         dispatch_imm_i = $urandom;
         dispatch_if_write_rrf_i = $urandom_range(0, 1);
         dispatch_rrf_tag_i = 6'($urandom_range(0, 63));
         wb_valid_i = $urandom_range(0, 1);
         wb_tag_i = 6'($urandom_range(0, 7));
         wb_data_i = $urandom;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
